// File: rtl/mouse_cursor_overlay.sv
// rtl/mouse_cursor_overlay.sv - 16x16 arrow cursor overlay on the 3-bit VGA stream with click capture
// Two-stage pixel pipeline on PIX_EN; mouse inputs resynchronised and skew-filtered.
module mouse_cursor_overlay #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int RST_X    = 320,
    parameter int RST_Y    = 199
) (
    input  logic        CLK_50MHZ,
    input  logic        MASTER_RST,
    input  logic        PIX_EN,
    input  logic [11:0] HCOUNT,
    input  logic [11:0] VCOUNT,
    input  logic [2:0]  RGB_IN,
    input  logic [11:0] XCOORD,
    input  logic [11:0] YCOORD,
    input  logic        L_BUTTON,
    input  logic        M_BUTTON,
    input  logic        R_BUTTON,
    output logic [2:0]  RGB_OUT,
    output logic        CURSOR_ON,
    output logic        L_CLICK,
    output logic        R_CLICK,
    output logic [11:0] CLICK_X,
    output logic [11:0] CLICK_Y
);

    localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
    localparam logic [11:0] X_RST = 12'(RST_X);
    localparam logic [11:0] Y_RST = 12'(RST_Y);

    // Each row holds 16 two-bit codes, leftmost pixel in the top bits.
    function automatic logic [1:0] sprite_code(input logic [7:0] addr);
        logic [31:0] row;
        logic [31:0] shifted;
        case (addr[7:4])
            4'd0:    row = 32'h4000_0000;
            4'd1:    row = 32'h5000_0000;
            4'd2:    row = 32'h6400_0000;
            4'd3:    row = 32'h6900_0000;
            4'd4:    row = 32'h6A40_0000;
            4'd5:    row = 32'h6A90_0000;
            4'd6:    row = 32'h6AA4_0000;
            4'd7:    row = 32'h6AA9_0000;
            4'd8:    row = 32'h6AAA_4000;
            4'd9:    row = 32'h6AAA_9000;
            4'd10:   row = 32'h6AA5_5400;
            4'd11:   row = 32'h69A4_0000;
            4'd12:   row = 32'h6469_0000;
            4'd13:   row = 32'h5069_0000;
            4'd14:   row = 32'h401A_4000;
            default: row = 32'h007D_0000;
        endcase
        shifted = row << {addr[3:0], 1'b0};
        return shifted[31:30];
    endfunction

    logic [11:0] x_s1_q, x_s2_q, x_prev_q;
    logic [11:0] y_s1_q, y_s2_q, y_prev_q;
    logic [2:0]  btn_s1_q, btn_s2_q, btn_prev_q;
    logic [11:0] stable_x_q, stable_y_q;
    logic [11:0] cur_x_q, cur_y_q;
    logic        win_q, act_q;
    logic [7:0]  addr_q;
    logic [2:0]  rgb_dly_q;
    logic [2:0]  rgb_out_q;
    logic        cursor_on_q;
    logic        l_click_q, r_click_q;
    logic [11:0] click_x_q, click_y_q;

    logic [12:0] dx, dy;
    logic        active_d, win_d, latch_d, stable_ok;
    logic [7:0]  addr_d;
    logic [1:0]  code;
    logic [2:0]  fill;
    logic [2:0]  rgb_out_d;
    logic        cursor_on_d;
    logic        l_click_d, r_click_d;

    always_comb begin
        dx          = {1'b0, HCOUNT} - {1'b0, cur_x_q};
        dy          = {1'b0, VCOUNT} - {1'b0, cur_y_q};
        active_d    = (HCOUNT < H_ACT) && (VCOUNT < V_ACT);
        win_d       = (HCOUNT >= cur_x_q) && (dx <= 13'd15) &&
                      (VCOUNT >= cur_y_q) && (dy <= 13'd15) && active_d;
        addr_d      = {dy[3:0], dx[3:0]};
        latch_d     = PIX_EN && (HCOUNT == 12'd0) && (VCOUNT == V_ACT);
        stable_ok   = (x_s2_q == x_prev_q) && (y_s2_q == y_prev_q);
        l_click_d   = btn_s2_q[2] && !btn_prev_q[2];
        r_click_d   = btn_s2_q[0] && !btn_prev_q[0];

        code        = sprite_code(addr_q);
        fill        = (|btn_s2_q) ? 3'b110 : 3'b111;
        rgb_out_d   = rgb_dly_q;
        cursor_on_d = 1'b0;
        if (!act_q) begin
            rgb_out_d = 3'b000;
        end else if (win_q && code != 2'b00) begin
            cursor_on_d = 1'b1;
            case (code)
                2'b01:   rgb_out_d = 3'b000;
                2'b10:   rgb_out_d = fill;
                default: rgb_out_d = ~rgb_dly_q;
            endcase
        end
    end

    always_ff @(posedge CLK_50MHZ or posedge MASTER_RST) begin
        if (MASTER_RST) begin
            x_s1_q      <= '0;
            x_s2_q      <= '0;
            x_prev_q    <= '0;
            y_s1_q      <= '0;
            y_s2_q      <= '0;
            y_prev_q    <= '0;
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
            btn_prev_q  <= '0;
            stable_x_q  <= X_RST;
            stable_y_q  <= Y_RST;
            cur_x_q     <= X_RST;
            cur_y_q     <= Y_RST;
            win_q       <= 1'b0;
            act_q       <= 1'b0;
            addr_q      <= '0;
            rgb_dly_q   <= '0;
            rgb_out_q   <= '0;
            cursor_on_q <= 1'b0;
            l_click_q   <= 1'b0;
            r_click_q   <= 1'b0;
            click_x_q   <= X_RST;
            click_y_q   <= Y_RST;
        end else begin
            x_s1_q     <= XCOORD;
            x_s2_q     <= x_s1_q;
            x_prev_q   <= x_s2_q;
            y_s1_q     <= YCOORD;
            y_s2_q     <= y_s1_q;
            y_prev_q   <= y_s2_q;
            btn_s1_q   <= {L_BUTTON, M_BUTTON, R_BUTTON};
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            // Only a pair seen unchanged for two cycles is trusted.
            if (stable_ok) begin
                stable_x_q <= x_s2_q;
                stable_y_q <= y_s2_q;
            end
            if (latch_d) begin
                cur_x_q <= stable_x_q;
                cur_y_q <= stable_y_q;
            end
            if (PIX_EN) begin
                win_q       <= win_d;
                act_q       <= active_d;
                addr_q      <= addr_d;
                rgb_dly_q   <= RGB_IN;
                rgb_out_q   <= rgb_out_d;
                cursor_on_q <= cursor_on_d;
            end
            l_click_q <= l_click_d;
            r_click_q <= r_click_d;
            if (l_click_d || r_click_d) begin
                click_x_q <= stable_x_q;
                click_y_q <= stable_y_q;
            end
        end
    end

    assign RGB_OUT   = rgb_out_q;
    assign CURSOR_ON = cursor_on_q;
    assign L_CLICK   = l_click_q;
    assign R_CLICK   = r_click_q;
    assign CLICK_X   = click_x_q;
    assign CLICK_Y   = click_y_q;

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// tb/tb_mouse_cursor_overlay.sv - self-checking bench for mouse_cursor_overlay
module tb_mouse_cursor_overlay;

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;
    localparam int RX    = 320;
    localparam int RY    = 199;

    logic        clk = 1'b0;
    logic        MASTER_RST;
    logic        PIX_EN;
    logic [11:0] HCOUNT, VCOUNT, XCOORD, YCOORD;
    logic [2:0]  RGB_IN;
    logic        L_BUTTON, M_BUTTON, R_BUTTON;
    logic [2:0]  RGB_OUT;
    logic        CURSOR_ON, L_CLICK, R_CLICK;
    logic [11:0] CLICK_X, CLICK_Y;

    mouse_cursor_overlay #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .RST_X(RX), .RST_Y(RY)
    ) dut (
        .CLK_50MHZ(clk), .MASTER_RST(MASTER_RST), .PIX_EN(PIX_EN),
        .HCOUNT(HCOUNT), .VCOUNT(VCOUNT), .RGB_IN(RGB_IN),
        .XCOORD(XCOORD), .YCOORD(YCOORD),
        .L_BUTTON(L_BUTTON), .M_BUTTON(M_BUTTON), .R_BUTTON(R_BUTTON),
        .RGB_OUT(RGB_OUT), .CURSOR_ON(CURSOR_ON),
        .L_CLICK(L_CLICK), .R_CLICK(R_CLICK),
        .CLICK_X(CLICK_X), .CLICK_Y(CLICK_Y)
    );

    always #10 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         mcx, mcy, mstx, msty;
    logic       mbtn;
    string      spr [16];
    logic [3:0] expq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string pad16(input string s);
        string r = s;
        while (r.len() < 16) r = {r, "."};
        return r;
    endfunction

    // Expected {CURSOR_ON, RGB_OUT} for one pixel, from the picture of the arrow.
    function automatic logic [3:0] model(input int h, input int v, input logic [2:0] rgb);
        string row;
        byte   c;
        if (h >= H_ACT || v >= V_ACT) return 4'b0000;
        if (h >= mcx && h <= mcx + 15 && v >= mcy && v <= mcy + 15) begin
            row = spr[v - mcy];
            c   = row[h - mcx];
            case (c)
                "B":     return {1'b1, 3'b000};
                "W":     return {1'b1, mbtn ? 3'b110 : 3'b111};
                "I":     return {1'b1, ~rgb};
                default: return {1'b0, rgb};
            endcase
        end
        return {1'b0, rgb};
    endfunction

    task automatic pix(input int h, input int v, input logic [2:0] rgb);
        logic [3:0] e, got;
        @(negedge clk);
        HCOUNT = 12'(h);
        VCOUNT = 12'(v);
        RGB_IN = rgb;
        PIX_EN = 1'b1;
        expq.push_back(model(h, v, rgb));
        if (h == 0 && v == V_ACT) begin
            mcx = mstx;
            mcy = msty;
        end
        @(posedge clk);
        #1;
        e   = expq.pop_front();
        got = {CURSOR_ON, RGB_OUT};
        chk($sformatf("pix h=%0d v=%0d", h, v), 32'(got), 32'(e));
        @(negedge clk);
        PIX_EN = 1'b0;
        @(posedge clk);
        #1;
        got = {CURSOR_ON, RGB_OUT};
        chk($sformatf("hold h=%0d v=%0d", h, v), 32'(got), 32'(e));
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1,
                        input bit fixed, input logic [2:0] frgb);
        for (int v = (y0 < 0 ? 0 : y0); v <= y1; v++)
            for (int h = (x0 < 0 ? 0 : x0); h <= x1; h++)
                pix(h, v, fixed ? frgb : 3'($urandom_range(0, 7)));
    endtask

    task automatic set_xy(input int x, input int y);
        @(negedge clk);
        XCOORD = 12'(x);
        YCOORD = 12'(y);
        mstx   = x;
        msty   = y;
        repeat (8) @(negedge clk);
    endtask

    task automatic set_btn(input logic l, input logic m, input logic r);
        @(negedge clk);
        L_BUTTON = l;
        M_BUTTON = m;
        R_BUTTON = r;
        mbtn     = l | m | r;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " RGB_OUT"}, 32'(RGB_OUT), 32'd0);
        chk({tag, " CURSOR_ON"}, 32'(CURSOR_ON), 32'd0);
        chk({tag, " L_CLICK"}, 32'(L_CLICK), 32'd0);
        chk({tag, " R_CLICK"}, 32'(R_CLICK), 32'd0);
        chk({tag, " CLICK_X"}, 32'(CLICK_X), 32'(RX));
        chk({tag, " CLICK_Y"}, 32'(CLICK_Y), 32'(RY));
    endtask

    task automatic model_reset();
        mcx  = RX;
        mcy  = RY;
        mbtn = 1'b0;
        expq.delete();
        expq.push_back(4'b0000);
    endtask

    initial begin
        int lcnt, rcnt, lat, rat, x, y;
        spr[0]  = pad16("B");
        spr[1]  = pad16("BB");
        spr[2]  = pad16("BWB");
        spr[3]  = pad16("BWWB");
        spr[4]  = pad16("BWWWB");
        spr[5]  = pad16("BWWWWB");
        spr[6]  = pad16("BWWWWWB");
        spr[7]  = pad16("BWWWWWWB");
        spr[8]  = pad16("BWWWWWWWB");
        spr[9]  = pad16("BWWWWWWWWB");
        spr[10] = pad16("BWWWWWBBBBB");
        spr[11] = pad16("BWWBWWB");
        spr[12] = pad16("BWB.BWWB");
        spr[13] = pad16("BB..BWWB");
        spr[14] = pad16("B....BWWB");
        spr[15] = pad16("....BIIB");

        MASTER_RST = 1'b1;
        PIX_EN     = 1'b0;
        HCOUNT     = '0;
        VCOUNT     = '0;
        RGB_IN     = '0;
        XCOORD     = 12'(RX);
        YCOORD     = 12'(RY);
        mstx       = RX;
        msty       = RY;
        L_BUTTON   = 1'b0;
        M_BUTTON   = 1'b0;
        R_BUTTON   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        MASTER_RST = 1'b0;
        repeat (6) @(negedge clk);

        // Cursor at reset position, constant background.
        scan(312, 340, 193, 219, 1'b1, 3'b010);
        repeat (200) pix($urandom_range(0, 700), $urandom_range(0, 479), 3'b010);

        // Move mid-frame: current frame keeps the old X.
        set_xy(100, 100);
        pix(0, V_ACT, 3'b000);
        scan(96, 118, 97, 99, 1'b0, 3'b000);
        set_xy(200, 100);
        scan(96, 118, 100, 117, 1'b0, 3'b000);
        scan(196, 218, 98, 117, 1'b0, 3'b000);
        pix(5, V_ACT, 3'b000);
        pix(0, V_ACT - 1, 3'b000);
        scan(196, 218, 98, 104, 1'b0, 3'b000);
        pix(0, V_ACT, 3'b000);
        scan(196, 218, 98, 117, 1'b0, 3'b000);
        scan(96, 118, 98, 104, 1'b0, 3'b000);

        // Clipping at right/bottom edge, no wrap.
        set_xy(630, 470);
        pix(0, V_ACT, 3'b000);
        scan(624, 645, 464, 485, 1'b0, 3'b000);
        scan(0, 5, 464, 485, 1'b0, 3'b000);
        scan(624, 645, 0, 5, 1'b0, 3'b000);
        scan(0, 5, 0, 5, 1'b0, 3'b000);

        // Fill colour follows button state.
        set_xy(40, 40);
        pix(0, V_ACT, 3'b000);
        set_btn(1'b0, 1'b1, 1'b0);
        scan(40, 55, 40, 55, 1'b0, 3'b000);
        set_btn(1'b0, 1'b0, 1'b0);
        scan(40, 55, 40, 55, 1'b0, 3'b000);

        // Random positions and buttons.
        repeat (4) begin
            x = $urandom_range(0, 650);
            y = $urandom_range(0, 490);
            set_xy(x, y);
            pix(0, V_ACT, 3'b000);
            set_btn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            scan(x - 2, x + 17, y - 2, y + 17, 1'b0, 3'b000);
            set_btn(1'b0, 1'b0, 1'b0);
        end

        // Simultaneous L+R press held for 1000 cycles.
        set_xy(50, 60);
        @(negedge clk);
        L_BUTTON = 1'b1;
        R_BUTTON = 1'b1;
        lcnt = 0; rcnt = 0; lat = -1; rat = -1;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk);
            #1;
            if (L_CLICK) begin lcnt++; lat = i; end
            if (R_CLICK) begin rcnt++; rat = i; end
        end
        chk("l_click count", 32'(lcnt), 32'd1);
        chk("r_click count", 32'(rcnt), 32'd1);
        chk("l_click latency", 32'(lat), 32'd3);
        chk("r_click latency", 32'(rat), 32'd3);
        chk("click_x", 32'(CLICK_X), 32'd50);
        chk("click_y", 32'(CLICK_Y), 32'd60);
        @(negedge clk);
        L_BUTTON = 1'b0;
        R_BUTTON = 1'b0;
        lcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (L_CLICK || R_CLICK) lcnt++;
        end
        chk("release pulses", 32'(lcnt), 32'd0);
        mbtn = 1'b0;

        // Reset asserted during an L_CLICK pulse.
        pix(10, 10, 3'b101);
        pix(10, 10, 3'b101);
        @(negedge clk);
        L_BUTTON = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset L_CLICK", 32'(L_CLICK), 32'd1);
        chk("pre-reset RGB_OUT", 32'(RGB_OUT), 32'd5);
        MASTER_RST = 1'b1;
        #1;
        check_reset_outputs("async reset");
        @(negedge clk);
        L_BUTTON = 1'b0;
        @(negedge clk);
        MASTER_RST = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        scan(316, 338, 196, 216, 1'b0, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mouse_cursor_overlay.md
# mouse_cursor_overlay

Sits between the VGA pixel pipeline and the display output, directly downstream of the PS/2 mouse driver. It takes the driver's cursor coordinates and button levels and overlays a 16x16 two-bit arrow sprite on the incoming 3-bit RGB stream. It also turns left and right button presses into single-cycle click events tagged with the cursor position, for the oscilloscope UI logic.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- RST_X, 320, cursor X after reset
- RST_Y, 199, cursor Y after reset

Ports:
- CLK_50MHZ  in  1  system clock
- MASTER_RST  in  1  reset, asynchronous, active-high
- PIX_EN  in  1  pixel strobe, one CLK_50MHZ cycle in every two
- HCOUNT  in  12  current pixel column from the VGA timing block
- VCOUNT  in  12  current line from the VGA timing block
- RGB_IN  in  3  background pixel {R,G,B}
- XCOORD  in  12  cursor X from the mouse driver (asynchronous domain)
- YCOORD  in  12  cursor Y from the mouse driver (asynchronous domain)
- L_BUTTON, M_BUTTON, R_BUTTON  in  1 each  button levels (asynchronous domain)
- RGB_OUT  out  3  composited pixel
- CURSOR_ON  out  1  high when RGB_OUT is a non-transparent sprite pixel
- L_CLICK  out  1  one-cycle pulse on a left press
- R_CLICK  out  1  one-cycle pulse on a right press
- CLICK_X  out  12  X latched at the most recent click
- CLICK_Y  out  12  Y latched at the most recent click

## Operation
- **Input synchronisation**
  - XCOORD, YCOORD and all buttons pass through two flops each.
  - A new coordinate pair is accepted into stable_x/stable_y only when the synchronised X and Y values equal those of the previous cycle. This rejects multi-bit skew.
- **Frame latch**
  - cur_x/cur_y load from stable_x/stable_y on the cycle where PIX_EN=1, HCOUNT=0 and VCOUNT=V_ACTIVE.
  - The cursor therefore never moves mid-frame.
- **Window test (stage 1, on PIX_EN)**
  - Compute dx = HCOUNT - cur_x and dy = VCOUNT - cur_y, each 13-bit unsigned.
  - in_win = (HCOUNT >= cur_x) && (dx <= 15) && (VCOUNT >= cur_y) && (dy <= 15) && (HCOUNT < H_ACTIVE) && (VCOUNT < V_ACTIVE).
  - Sprite address = {dy[3:0], dx[3:0]}.
  - Register in_win, the address and RGB_IN.
- **Sprite ROM**
  - Fixed 256x2 arrow with the hotspot at the top-left pixel.
  - Codes: 00 transparent, 01 border (black 3'b000), 10 fill, 11 invert.
  - Fill colour is white 3'b111. It is yellow 3'b110 while any synchronised button is held.
- **Composite (stage 2, on PIX_EN)**
  - in_win=0 or code 00: RGB_OUT = delayed RGB_IN, CURSOR_ON=0.
  - Otherwise: RGB_OUT = border colour, fill colour, or ~RGB_IN according to the code, and CURSOR_ON=1.
  - If the delayed pixel lies outside the active area, RGB_OUT=0.
- **Clipping**
  - A cursor near the right or bottom edge is drawn only partially.
  - There is no wrap to column 0 or line 0.
- **Clicks**
  - A rising edge of synchronised L_BUTTON (or R_BUTTON) pulses L_CLICK (or R_CLICK) high for exactly one CLK_50MHZ cycle.
  - On that same edge, CLICK_X/CLICK_Y <= stable_x/stable_y. These are not the frame-latched values.
  - L and R rising in the same cycle: both pulses fire and share one coordinate capture.
  - Holding a button produces no repeat pulses.
  - M_BUTTON only affects the fill colour.

## Timing
- Reset values: RGB_OUT=0, CURSOR_ON=0, L_CLICK=0, R_CLICK=0, CLICK_X=RST_X, CLICK_Y=RST_Y.
- Also on reset: cur_x, stable_x = RST_X; cur_y, stable_y = RST_Y; all pipeline and synchroniser flops = 0.
- Pixel latency is 2 PIX_EN strobes from RGB_IN/HCOUNT/VCOUNT to RGB_OUT/CURSOR_ON. The VGA timing block delays HSYNC/VSYNC by 2 pixels to match.
- Outputs hold between PIX_EN strobes.
- Click latency is 3 CLK_50MHZ cycles from the button edge at the input to the L_CLICK/R_CLICK pulse.
- Coordinate latency: a pair applies from the first frame latch at least 4 cycles after XCOORD/YCOORD settle.
- Reset asserted mid-frame clears everything immediately. After release, RGB_OUT=0 for 2 strobes, then normal passthrough; the cursor draws at RST_X/RST_Y until the next frame latch.

## Test plan
- **Reset draw:** Reset, drive a full frame with RGB_IN=3'b010 and XCOORD/YCOORD=320/199. Required: sprite pixels are confined to columns 320..335 and lines 199..214, and every other active pixel outputs 3'b010.
- **Mid-frame move:** Change XCOORD 100 -> 200 at VCOUNT=100. Required: the current frame still draws at X=100; the next frame draws at X=200.
- **Edge clipping:** XCOORD=630, YCOORD=470. Required: CURSOR_ON is asserted only for HCOUNT 630..639 and VCOUNT 470..479, and never at HCOUNT 0..5 or VCOUNT 0..5.
- **Fill colour:** Hold M_BUTTON=1. Required: fill pixels output 3'b110 and border pixels 3'b000; on release, fill returns to 3'b111.
- **Click capture:** With X=50, Y=60, press L and R in the same cycle and hold for 1000 cycles. Required: a single one-cycle L_CLICK and a single one-cycle R_CLICK, CLICK_X=50, CLICK_Y=60, and no further pulses.
- **Reset mid-operation:** Assert MASTER_RST during an L_CLICK pulse. Required: all outputs return to their reset values asynchronously, in the same cycle.
